// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for one CNN inference: feeder enable, pixel-beat count, result capture, error codes.
// Optional build macro SEQ_STATS_EN adds the frame and error statistics counters.
module cnn_frame_sequencer #(
  parameter int TOTAL_PIXELS = 784,
  parameter int CLASS_BW     = 5,
  parameter int FEED_TIMEOUT = 16,
  parameter int RES_TIMEOUT  = 4096
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_start,
  input  logic                                  i_abort,
  output logic                                  o_feed_en,
  input  logic                                  i_feed_valid,
  input  logic                                  i_cnn_valid,
  input  logic [CLASS_BW-1:0]                   i_cnn_class,
  output logic                                  o_busy,
  output logic                                  o_result_valid,
  output logic [CLASS_BW-1:0]                   o_result_class,
  output logic [1:0]                            o_error,
  output logic [$clog2(TOTAL_PIXELS+1)-1:0]     o_pix_cnt
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]                           o_frame_cnt,
  output logic [7:0]                            o_err_cnt
`endif
);

  // state    | meaning
  // IDLE     | waiting for i_start
  // ARM      | feeder enabled, waiting for first pixel beat
  // FEED     | counting gap-free pixel beats
  // WAIT_RES | frame complete, waiting for CNN result
  // DONE     | one-cycle result pulse
  // ERR      | error code held until restart or abort

  localparam int PW   = $clog2(TOTAL_PIXELS+1);
  localparam int MAXT = (RES_TIMEOUT > FEED_TIMEOUT) ? RES_TIMEOUT : FEED_TIMEOUT;
  localparam int TW   = (MAXT > 2) ? $clog2(MAXT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FEED, S_WAIT_RES, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          err_code;
  logic [TW-1:0]       timer_q, timer_d;
  logic [PW-1:0]       pix_q, pix_d;
  logic [1:0]          err_q, err_d;
  logic [CLASS_BW-1:0] class_q, class_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Abort outranks every other transition; overrun outranks a coincident result.
  always_comb begin
    state_d  = state_q;
    err_code = 2'b00;
    if (i_abort && (state_q inside {S_ARM, S_FEED, S_WAIT_RES, S_ERR})) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) state_d = S_ARM;
        S_ARM: begin
          if (i_feed_valid) begin
            state_d = (TOTAL_PIXELS <= 1) ? S_WAIT_RES : S_FEED;
          end else if (timer_q == '0) begin
            state_d  = S_ERR;
            err_code = 2'b01;
          end
        end
        S_FEED: begin
          if (!i_feed_valid) begin
            state_d  = S_ERR;
            err_code = 2'b10;
          end else if (pix_q == PW'(TOTAL_PIXELS-1)) begin
            state_d = S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (i_feed_valid) begin
            state_d  = S_ERR;
            err_code = 2'b11;
          end else if (i_cnn_valid) begin
            state_d = S_DONE;
          end else if (timer_q == '0) begin
            state_d  = S_ERR;
            err_code = 2'b11;
          end
        end
        S_DONE: state_d = S_IDLE;
        S_ERR:  if (i_start) state_d = S_ARM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_feed_en      = (state_q == S_ARM) || (state_q == S_FEED);
    o_busy         = (state_q == S_ARM) || (state_q == S_FEED) || (state_q == S_WAIT_RES);
    o_result_valid = (state_q == S_DONE);
    o_result_class = class_q;
    o_error        = err_q;
    o_pix_cnt      = pix_q;
  end

  // Shared down-counter: loaded with timeout-1 on ARM / WAIT_RES entry, terminal count at zero.
  always_comb begin
    timer_d = timer_q;
    pix_d   = pix_q;
    err_d   = err_q;
    class_d = class_q;
    if (state_d == S_ARM && state_q != S_ARM) begin
      timer_d = TW'(FEED_TIMEOUT-1);
      pix_d   = '0;
      err_d   = 2'b00;
    end else if (state_d == S_WAIT_RES && state_q != S_WAIT_RES) begin
      timer_d = TW'(RES_TIMEOUT-1);
    end else if ((state_q == S_ARM || state_q == S_WAIT_RES) && timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
    if ((state_q == S_ARM || state_q == S_FEED) && i_feed_valid && !i_abort
        && pix_q != PW'(TOTAL_PIXELS)) begin
      pix_d = pix_q + PW'(1);
    end
    if (state_q == S_WAIT_RES && state_d == S_DONE) class_d = i_cnn_class;
    if (state_d == S_ERR && state_q != S_ERR)       err_d   = err_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      pix_q   <= '0;
      err_q   <= 2'b00;
      class_q <= '0;
    end else begin
      timer_q <= timer_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
      class_q <= class_d;
    end
  end

`ifdef SEQ_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (state_d == S_DONE && state_q != S_DONE && frame_cnt_q != 16'hFFFF)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_d == S_ERR && state_q != S_ERR && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Randomized frame-level bench for cnn_frame_sequencer; expected outcome of each frame
// is derived from its stimulus parameters (start delay, beat count, result delay, overrun).
module tb_cnn_frame_sequencer;
  localparam int TP  = 784;
  localparam int CBW = 5;
  localparam int FT  = 16;
  localparam int RT  = 4096;
  localparam int PW  = $clog2(TP+1);

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start, i_abort, i_feed_valid, i_cnn_valid;
  logic [CBW-1:0] i_cnn_class;
  logic           o_feed_en, o_busy, o_result_valid;
  logic [CBW-1:0] o_result_class;
  logic [1:0]     o_error;
  logic [PW-1:0]  o_pix_cnt;
`ifdef SEQ_STATS_EN
  logic [15:0]    o_frame_cnt;
  logic [7:0]     o_err_cnt;
`endif

  always #5 clk = ~clk;

  cnn_frame_sequencer #(
    .TOTAL_PIXELS(TP), .CLASS_BW(CBW), .FEED_TIMEOUT(FT), .RES_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .o_feed_en(o_feed_en), .i_feed_valid(i_feed_valid),
    .i_cnn_valid(i_cnn_valid), .i_cnn_class(i_cnn_class),
    .o_busy(o_busy), .o_result_valid(o_result_valid),
    .o_result_class(o_result_class), .o_error(o_error), .o_pix_cnt(o_pix_cnt)
`ifdef SEQ_STATS_EN
    , .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
`endif
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int feed_hi, rv_cnt, rv_cyc, rv_class, cnn_cyc;
  int model_class = 0;
  int good_frames = 0, err_frames = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (o_feed_en) feed_hi++;
    if (o_result_valid) begin
      rv_cnt++;
      rv_cyc   = cyc;
      rv_class = int'(o_result_class);
    end
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_abort = 1'b0; i_feed_valid = 1'b0;
    i_cnn_valid = 1'b0; i_cnn_class = '0;
  endtask

  // d: idle cycles after enable before first beat; n: contiguous beats;
  // ovr: extra beat after the frame (with coincident result if ovr_cnn); rd: cycles before result.
  task automatic run_frame(input int d, input int n, input bit ovr, input bit ovr_cnn,
                           input int rd, input int cls, input bit noise);
    int e_err, e_pix, e_rv, e_feed;
    if (d >= FT) begin
      e_err = 1; e_pix = 0; e_rv = 0; e_feed = FT;
    end else if (n < TP) begin
      e_err = 2; e_pix = n; e_rv = 0; e_feed = d + n + 1;
    end else begin
      e_pix = TP; e_feed = d + TP;
      if (ovr || rd >= RT) begin e_err = 3; e_rv = 0; end
      else begin e_err = 0; e_rv = 1; end
    end

    feed_hi = 0; rv_cnt = 0; rv_cyc = -1; cnn_cyc = -1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("err_clr_on_arm", int'(o_error), 0);
    chk("busy_in_arm", int'(o_busy), 1);
    for (int k = 0; k < d; k++) begin
      i_feed_valid = 1'b0;
      i_cnn_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    for (int b = 0; b < n; b++) begin
      i_feed_valid = 1'b1;
      i_start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_cnn_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_cnn_class  = CBW'($urandom_range(0, 31));
      step();
    end
    i_start = 1'b0; i_cnn_valid = 1'b0; i_feed_valid = 1'b0;
    if (d < FT && n == TP) begin
      if (ovr) begin
        i_feed_valid = 1'b1; i_cnn_valid = ovr_cnn; i_cnn_class = CBW'(cls);
        step();
        i_feed_valid = 1'b0; i_cnn_valid = 1'b0;
      end else begin
        for (int k = 0; k < rd; k++) step();
        i_cnn_valid = 1'b1; i_cnn_class = CBW'(cls); cnn_cyc = cyc;
        step();
        i_cnn_valid = 1'b0;
        if (e_rv == 1) begin
          i_start = 1'b1;
          step();
          i_start = 1'b0;
        end
      end
    end
    repeat (3) step();

    chk("error_code", int'(o_error), e_err);
    chk("pix_cnt", int'(o_pix_cnt), e_pix);
    chk("result_pulses", rv_cnt, e_rv);
    chk("feed_en_cycles", feed_hi, e_feed);
    chk("busy_after", int'(o_busy), 0);
    chk("feed_en_after", int'(o_feed_en), 0);
    if (e_rv == 1) begin
      model_class = cls;
      good_frames++;
      chk("result_latency", rv_cyc, cnn_cyc + 1);
      chk("result_class_pulse", rv_class, cls);
    end else begin
      err_frames++;
    end
    chk("result_class_hold", int'(o_result_class), model_class);
  endtask

  // Starts a frame and interrupts it on beat 300 with abort or reset.
  task automatic interrupt_frame(input bit use_reset);
    feed_hi = 0; rv_cnt = 0;
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (2) step();
    for (int b = 0; b < 299; b++) begin i_feed_valid = 1'b1; step(); end
    if (use_reset) reset = 1'b1; else i_abort = 1'b1;
    step();
    reset = 1'b0; i_abort = 1'b0; i_feed_valid = 1'b0;
    chk(use_reset ? "rst_feed_en" : "abort_feed_en", int'(o_feed_en), 0);
    chk(use_reset ? "rst_busy" : "abort_busy", int'(o_busy), 0);
    chk(use_reset ? "rst_error" : "abort_error", int'(o_error), 0);
    if (use_reset) begin
      model_class = 0; good_frames = 0; err_frames = 0;
      chk("rst_pix_cnt", int'(o_pix_cnt), 0);
      chk("rst_result_class", int'(o_result_class), 0);
      chk("rst_result_valid", int'(o_result_valid), 0);
    end
    repeat (2) step();
    chk("interrupt_no_result", rv_cnt, 0);
    chk("interrupt_idle", int'(o_busy), 0);
  endtask

  initial begin
    int kind, d, n, rd;
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_feed_en", int'(o_feed_en), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_result_valid", int'(o_result_valid), 0);
    chk("reset_result_class", int'(o_result_class), 0);
    chk("reset_error", int'(o_error), 0);
    chk("reset_pix_cnt", int'(o_pix_cnt), 0);

    run_frame(2, TP, 1'b0, 1'b0, 100, 7, 1'b0);
    run_frame(FT, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    i_abort = 1'b1; step(); i_abort = 1'b0; step();
    chk("err_kept_after_abort", int'(o_error), 1);
    chk("err_abort_idle", int'(o_busy), 0);
    run_frame(FT-1, TP, 1'b0, 1'b0, 5, 3, 1'b1);
    run_frame(1, 500, 1'b0, 1'b0, 0, 0, 1'b0);
    run_frame(0, TP, 1'b0, 1'b0, RT, 9, 1'b0);
    run_frame(0, TP, 1'b0, 1'b0, RT-1, 21, 1'b0);
    run_frame(3, TP, 1'b1, 1'b0, 0, 11, 1'b0);
    run_frame(3, TP, 1'b1, 1'b1, 0, 30, 1'b0);
    interrupt_frame(1'b0);
    run_frame(0, TP, 1'b0, 1'b0, 0, 12, 1'b1);
    interrupt_frame(1'b1);

    for (int f = 0; f < 10; f++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, FT-1);
      rd   = $urandom_range(0, 300);
      case (kind)
        0: run_frame(FT + $urandom_range(0, 4), 0, 1'b0, 1'b0, 0, 0, 1'b1);
        1: begin
          n = $urandom_range(1, TP-1);
          run_frame(d, n, 1'b0, 1'b0, 0, 0, 1'b1);
        end
        2: run_frame(d, TP, 1'b1, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 31), 1'b1);
        default: run_frame(d, TP, 1'b0, 1'b0, rd, $urandom_range(0, 31), 1'b1);
      endcase
    end

`ifdef SEQ_STATS_EN
    chk("stats_frame_cnt", int'(o_frame_cnt), good_frames);
    chk("stats_err_cnt", int'(o_err_cnt), err_frames);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Frame-level controller that runs one inference: pixel feeder → CNN top → result capture.
- On a host/button start request, holds the feeder enable high for one frame and counts the pixel beats the feeder returns.
- Then waits for the CNN classification result, latches it and reports it.
- Detects stalled, short and over-long frames and CNN result timeouts, and reports each with an error code.

Parameters:
- TOTAL_PIXELS, 784, pixel beats per frame (28x28)
- CLASS_BW, 5, width of the CNN class index
- FEED_TIMEOUT, 16, max cycles from enable assertion to first pixel valid
- RES_TIMEOUT, 4096, max cycles from last pixel to CNN result valid

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE and ERR
- i_abort  in  1  abort current frame; return to IDLE
- o_feed_en  out  1  level enable to the feeder; held high for the whole frame
- i_feed_valid  in  1  feeder pixel-valid, one per pixel beat
- i_cnn_valid  in  1  CNN result strobe
- i_cnn_class  in  CLASS_BW  CNN class index, qualified by i_cnn_valid
- o_busy  out  1  high in any state except IDLE, DONE, ERR
- o_result_valid  out  1  one-cycle pulse with a new result
- o_result_class  out  CLASS_BW  last captured class; holds until the next capture
- o_error  out  2  00 none, 01 feed timeout, 10 short frame, 11 result timeout / overrun
- o_pix_cnt  out  $clog2(TOTAL_PIXELS+1)  pixel beats counted in the current frame

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous, active-high.
  - Reset drives all outputs to 0 and the state to IDLE; all counters clear.
  - Reset mid-frame has the same effect.
- IDLE:
  - i_start=1 → ARM. o_feed_en rises on the next edge.
  - o_pix_cnt and o_error clear on the same edge.
- ARM:
  - o_feed_en=1; the wait counter counts cycles.
  - First i_feed_valid → FEED; that beat is counted (pix_cnt=1).
  - Wait counter reaches FEED_TIMEOUT with no valid → ERR, code 01.
- FEED:
  - o_feed_en=1; each i_feed_valid cycle increments pix_cnt.
  - Beat that makes pix_cnt==TOTAL_PIXELS → WAIT_RES. o_feed_en drops on that same edge; the feeder then resets its address.
  - i_feed_valid=0 while pix_cnt<TOTAL_PIXELS → ERR, code 10 (the feeder streams gap-free).
- WAIT_RES:
  - o_feed_en=0; the result counter counts.
  - i_cnn_valid=1 → latch i_cnn_class into o_result_class, then → DONE.
  - Result counter reaches RES_TIMEOUT → ERR, code 11.
  - Any i_feed_valid in this state → ERR, code 11 (overrun).
  - i_cnn_valid and overrun in the same cycle: error wins; the class is not latched.
- DONE:
  - o_result_valid=1 for exactly this one cycle, then → IDLE.
  - i_start in DONE is ignored (not queued).
- ERR:
  - o_error holds its code; o_feed_en=0.
  - i_start → ARM (the error clears on entry to ARM).
  - i_abort → IDLE with the error retained.
- i_abort:
  - In ARM, FEED or WAIT_RES → IDLE next edge; o_feed_en drops; no result; no error code.
  - Abort has priority over every other transition in the same cycle.
- Unqualified inputs:
  - i_start while busy is ignored.
  - i_cnn_valid outside WAIT_RES is ignored.
- Latency:
  - i_start → o_feed_en = 1 cycle.
  - Last pixel → o_feed_en low = same edge.
  - i_cnn_valid → o_result_valid = 1 cycle.
- Widths:
  - Counters saturate and never wrap.
  - o_pix_cnt holds its final value until the next ARM entry.

Optional Feature:
- Macro SEQ_STATS_EN.
- Defined:
  - Adds o_frame_cnt [15:0], counting DONE entries.
  - Adds o_err_cnt [7:0], counting ERR entries.
  - Both saturate at their maximum and clear only on reset.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Nominal frame:
  - Stimulus: i_start pulse; valid rises 2 cycles after o_feed_en; 784 contiguous beats; i_cnn_valid with class=7 after 100 cycles.
  - Response: o_feed_en high for exactly the ARM+784 valid cycles; o_result_valid one cycle later with o_result_class=7; o_pix_cnt=784; o_error=00.
- Feed timeout: i_start with no i_feed_valid → ERR after 16 cycles; o_error=01; o_feed_en=0.
- Short frame: valid drops after 500 beats → o_error=10; o_pix_cnt=500; no o_result_valid.
- Result timeout and overrun:
  - No i_cnn_valid for 4096 cycles → o_error=11.
  - Separate run with an extra valid beat after 784 → o_error=11.
- Abort, reset and busy start:
  - i_abort at beat 300 → IDLE; o_feed_en drops next edge; o_error=00.
  - Reset asserted at beat 300 → all outputs 0.
  - i_start during FEED is ignored.
- SEQ_STATS_EN build: 3 good frames, then 1 timeout → o_frame_cnt=3, o_err_cnt=1.
